// File: rtl/retire_unit_if.sv
// Bundle between the ROB head window / freddylist and the retirement logic.
// The master drives the ROB head and complete list; the slave (retire_unit) drives the results.
interface retire_unit_if #(
  parameter int N                = 3,
  parameter int PHYS_REG_SZ_R10K = 64,
  parameter int RETIRED_CNT_W    = 32
);
  localparam int NUM_SCALAR_BITS = $clog2(N + 1);
  localparam int PHYS_REG_IDX_W  = $clog2(PHYS_REG_SZ_R10K);

  typedef struct packed {
    logic [PHYS_REG_IDX_W-1:0] T_old;
    logic [PHYS_REG_IDX_W-1:0] T_new;
  } rob_packet_t;

  rob_packet_t [N-1:0]                     rob_outputs;
  logic [NUM_SCALAR_BITS-1:0]              rob_outputs_valid;
  logic [PHYS_REG_SZ_R10K-1:0]             complete_list_exposed;
  logic [NUM_SCALAR_BITS-1:0]              num_retiring;
  logic [N-1:0][PHYS_REG_IDX_W-1:0]        phys_regs_retiring;
  logic [RETIRED_CNT_W-1:0]                retired_count;

  modport master (
    output rob_outputs, rob_outputs_valid, complete_list_exposed,
    input  num_retiring, phys_regs_retiring, retired_count
  );

  modport slave (
    input  rob_outputs, rob_outputs_valid, complete_list_exposed,
    output num_retiring, phys_regs_retiring, retired_count
  );
endinterface

// File: rtl/retire_unit.sv
// Commit-stage retirement: retires the completed in-order prefix of the ROB head window.
// Optional macro RETIRE_SVA_EN compiles in clocked self-checks of the retire decision.
module retire_unit #(
  parameter int N                = 3,
  parameter int PHYS_REG_SZ_R10K = 64,
  parameter int RETIRED_CNT_W    = 32
) (
  input  logic         clock,
  input  logic         reset,
  retire_unit_if.slave bus
);
  localparam int NSB = $clog2(N + 1);

  logic [NSB-1:0]           valid_eff;
  logic [N-1:0]             entry_complete;
  logic [N-1:0]             entry_retire;
  logic [NSB-1:0]           num_retiring_c;
  logic [RETIRED_CNT_W-1:0] retired_count_q;
  logic [RETIRED_CNT_W-1:0] retired_count_d;

  assign valid_eff = (bus.rob_outputs_valid > NSB'(N)) ? NSB'(N) : bus.rob_outputs_valid;

  // entry_retire is a running AND, so it is always a contiguous prefix mask.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_entry
      assign entry_complete[gi] = (bus.rob_outputs[gi].T_new == '0) |
                                  bus.complete_list_exposed[bus.rob_outputs[gi].T_new];
      if (gi == 0) begin : g_head
        assign entry_retire[gi] = reset & (valid_eff != '0) & entry_complete[gi];
      end else begin : g_young
        assign entry_retire[gi] = entry_retire[gi-1] & (NSB'(gi) < valid_eff) & entry_complete[gi];
      end
      assign bus.phys_regs_retiring[gi] = entry_retire[gi] ? bus.rob_outputs[gi].T_old : '0;
    end
  endgenerate

  always_comb begin
    num_retiring_c = '0;
    for (int i = 0; i < N; i++) begin
      num_retiring_c = num_retiring_c + NSB'(entry_retire[i]);
    end
  end

  assign bus.num_retiring  = num_retiring_c;
  assign retired_count_d   = retired_count_q + RETIRED_CNT_W'(num_retiring_c);
  assign bus.retired_count = retired_count_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      retired_count_q <= '0;
    end else begin
      retired_count_q <= retired_count_d;
    end
  end

`ifdef RETIRE_SVA_EN
  logic [RETIRED_CNT_W-1:0] sva_count_q;
  logic [NSB-1:0]           sva_num_q;
  logic                     sva_live_q;

  always_ff @(posedge clock) begin
    sva_count_q <= retired_count_q;
    sva_num_q   <= num_retiring_c;
    sva_live_q  <= reset;
  end

  always @(posedge clock) begin
    if (reset) begin
      assert (num_retiring_c <= valid_eff)
        else $error("retire_unit: num_retiring exceeds valid count at %0t", $time);
      for (int i = 0; i < N; i++) begin
        if (NSB'(i) < num_retiring_c) begin
          assert (entry_complete[i])
            else $error("retire_unit: incomplete entry %0d retired at %0t", i, $time);
          assert (bus.phys_regs_retiring[i] == bus.rob_outputs[i].T_old)
            else $error("retire_unit: slot %0d not T_old at %0t", i, $time);
        end else begin
          assert (bus.phys_regs_retiring[i] == '0)
            else $error("retire_unit: idle slot %0d nonzero at %0t", i, $time);
        end
        if (NSB'(i) == num_retiring_c && NSB'(i) < valid_eff) begin
          assert (!entry_complete[i])
            else $error("retire_unit: complete entry %0d not retired at %0t", i, $time);
        end
      end
      if (sva_live_q) begin
        assert (retired_count_q == sva_count_q + RETIRED_CNT_W'(sva_num_q))
          else $error("retire_unit: retired_count advanced wrongly at %0t", $time);
      end
    end
  end
`else
  // Checking logic is absent in this build; behaviour is unchanged.
`endif
endmodule

// File: tb/tb_retire_unit.sv
// Directed and randomized checks of the retire prefix rule, slot outputs and counter.
module tb_retire_unit;
  localparam int N = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  retire_unit_if #(.N(N), .PHYS_REG_SZ_R10K(64), .RETIRED_CNT_W(32)) bus ();

  retire_unit #(.N(N), .PHYS_REG_SZ_R10K(64), .RETIRED_CNT_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_count = 0;
  logic [5:0]  t_old [N];
  logic [5:0]  t_new [N];

  task automatic apply(input logic [1:0] valid, input logic [63:0] cl);
    for (int i = 0; i < N; i++) begin
      bus.rob_outputs[i].T_old = t_old[i];
      bus.rob_outputs[i].T_new = t_new[i];
    end
    bus.rob_outputs_valid     = valid;
    bus.complete_list_exposed = cl;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    t_old = '{6'd1, 6'd2, 6'd3};
    t_new = '{6'd4, 6'd5, 6'd6};
    apply(2'd3, {64{1'b1}});
    n_cmp++;
    if (bus.num_retiring !== 2'd0) begin
      n_err++; $display("FAIL reset_num got %0d want 0", bus.num_retiring);
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (bus.phys_regs_retiring[i] !== 6'd0) begin
        n_err++; $display("FAIL reset_slot%0d got %0d want 0", i, bus.phys_regs_retiring[i]);
      end
    end
    tick();
    n_cmp++;
    if (bus.retired_count !== 32'd0) begin
      n_err++; $display("FAIL reset_count got %0d want 0", bus.retired_count);
    end
    $display("test_reset: num=%0d count=%0d", bus.num_retiring, bus.retired_count);
    bus.rob_outputs_valid = 2'd0;
    reset = 1'b1;
    exp_count = 0;
  endtask

  task automatic test_partial_valid();
    t_old = '{6'd5, 6'd9, 6'd12};
    t_new = '{6'd7, 6'd11, 6'd20};
    apply(2'd2, {64{1'b1}});
    n_cmp++;
    if (bus.num_retiring !== 2'd2) begin
      n_err++; $display("FAIL partial_num got %0d want 2", bus.num_retiring);
    end
    n_cmp++;
    if (bus.phys_regs_retiring[0] !== 6'd5 || bus.phys_regs_retiring[1] !== 6'd9 ||
        bus.phys_regs_retiring[2] !== 6'd0) begin
      n_err++; $display("FAIL partial_slots got %0d,%0d,%0d want 5,9,0", bus.phys_regs_retiring[0],
                        bus.phys_regs_retiring[1], bus.phys_regs_retiring[2]);
    end
    tick();
    exp_count += 2;
    n_cmp++;
    if (bus.retired_count !== exp_count) begin
      n_err++; $display("FAIL partial_count got %0d want %0d", bus.retired_count, exp_count);
    end
    $display("test_partial_valid: count=%0d", bus.retired_count);
  endtask

  task automatic test_blocked_prefix();
    logic [63:0] cl;
    cl = '0; cl[4] = 1'b1; cl[10] = 1'b1;
    t_old = '{6'd21, 6'd22, 6'd23};
    t_new = '{6'd4, 6'd8, 6'd10};
    apply(2'd3, cl);
    n_cmp++;
    if (bus.num_retiring !== 2'd1) begin
      n_err++; $display("FAIL blocked_num got %0d want 1", bus.num_retiring);
    end
    n_cmp++;
    if (bus.phys_regs_retiring[0] !== 6'd21 || bus.phys_regs_retiring[1] !== 6'd0 ||
        bus.phys_regs_retiring[2] !== 6'd0) begin
      n_err++; $display("FAIL blocked_slots got %0d,%0d,%0d want 21,0,0", bus.phys_regs_retiring[0],
                        bus.phys_regs_retiring[1], bus.phys_regs_retiring[2]);
    end
    tick();
    exp_count += 1;
    // Head entry incomplete: nothing retires even though entry 1 is complete.
    cl = '0; cl[8] = 1'b1;
    t_new = '{6'd4, 6'd8, 6'd10};
    apply(2'd3, cl);
    n_cmp++;
    if (bus.num_retiring !== 2'd0) begin
      n_err++; $display("FAIL head_blocked_num got %0d want 0", bus.num_retiring);
    end
    tick();
    n_cmp++;
    if (bus.retired_count !== exp_count) begin
      n_err++; $display("FAIL blocked_count got %0d want %0d", bus.retired_count, exp_count);
    end
    $display("test_blocked_prefix: count=%0d", bus.retired_count);
  endtask

  task automatic test_zero_valid();
    t_old = '{6'd30, 6'd31, 6'd32};
    t_new = '{6'd1, 6'd2, 6'd3};
    apply(2'd0, {64{1'b1}});
    n_cmp++;
    if (bus.num_retiring !== 2'd0 || bus.phys_regs_retiring !== '0) begin
      n_err++; $display("FAIL zero_valid got num=%0d slots=%h want 0,0", bus.num_retiring,
                        bus.phys_regs_retiring);
    end
    tick();
    n_cmp++;
    if (bus.retired_count !== exp_count) begin
      n_err++; $display("FAIL zero_valid_count got %0d want %0d", bus.retired_count, exp_count);
    end
    $display("test_zero_valid: count=%0d", bus.retired_count);
  endtask

  task automatic test_no_dest();
    t_old = '{6'd33, 6'd34, 6'd35};
    t_new = '{6'd0, 6'd0, 6'd0};
    apply(2'd1, 64'd0);
    n_cmp++;
    if (bus.num_retiring !== 2'd1 || bus.phys_regs_retiring[0] !== 6'd33 ||
        bus.phys_regs_retiring[1] !== 6'd0) begin
      n_err++; $display("FAIL no_dest got num=%0d slot0=%0d want 1,33", bus.num_retiring,
                        bus.phys_regs_retiring[0]);
    end
    tick();
    exp_count += 1;
    $display("test_no_dest: count=%0d", bus.retired_count);
  endtask

  task automatic test_duplicates();
    logic [63:0] cl;
    cl = '0; cl[7] = 1'b1;
    t_old = '{6'd40, 6'd41, 6'd42};
    t_new = '{6'd7, 6'd7, 6'd7};
    apply(2'd3, cl);
    n_cmp++;
    if (bus.num_retiring !== 2'd3 || bus.phys_regs_retiring[2] !== 6'd42) begin
      n_err++; $display("FAIL dup_all got num=%0d slot2=%0d want 3,42", bus.num_retiring,
                        bus.phys_regs_retiring[2]);
    end
    tick();
    exp_count += 3;
    t_new = '{6'd7, 6'd7, 6'd9};
    apply(2'd3, cl);
    n_cmp++;
    if (bus.num_retiring !== 2'd2 || bus.phys_regs_retiring[2] !== 6'd0) begin
      n_err++; $display("FAIL dup_partial got num=%0d slot2=%0d want 2,0", bus.num_retiring,
                        bus.phys_regs_retiring[2]);
    end
    tick();
    exp_count += 2;
    n_cmp++;
    if (bus.retired_count !== exp_count) begin
      n_err++; $display("FAIL dup_count got %0d want %0d", bus.retired_count, exp_count);
    end
    $display("test_duplicates: count=%0d", bus.retired_count);
  endtask

  task automatic test_random();
    logic [63:0] cl;
    logic [1:0]  valid;
    int          exp_num;
    bit          blocked;
    logic [5:0]  exp_slot [N];
    int          bad;
    for (int c = 0; c < 110; c++) begin
      for (int i = 0; i < N; i++) begin
        t_old[i] = 6'($urandom_range(63));
        t_new[i] = ($urandom_range(7) == 0) ? 6'd0 : 6'($urandom_range(63));
      end
      cl    = {$urandom | $urandom, $urandom | $urandom};
      valid = 2'($urandom_range(3, 1));
      apply(valid, cl);
      exp_num = 0;
      blocked = 1'b0;
      for (int i = 0; i < N; i++) begin
        exp_slot[i] = 6'd0;
        if (!blocked && i < int'(valid) && (t_new[i] == 6'd0 || cl[t_new[i]])) begin
          exp_num++;
          exp_slot[i] = t_old[i];
        end else begin
          blocked = 1'b1;
        end
      end
      bad = 0;
      for (int i = 0; i < N; i++) if (bus.phys_regs_retiring[i] !== exp_slot[i]) bad++;
      n_cmp++;
      if (bus.num_retiring !== 2'(exp_num) || bad != 0) begin
        n_err++; $display("FAIL rand_cycle%0d got num=%0d slots=%h want num=%0d", c,
                          bus.num_retiring, bus.phys_regs_retiring, exp_num);
      end
      tick();
      exp_count += 32'(exp_num);
      n_cmp++;
      if (bus.retired_count !== exp_count) begin
        n_err++; $display("FAIL rand_count%0d got %0d want %0d", c, bus.retired_count, exp_count);
      end
      $display("rand %0d: valid=%0d num=%0d count=%0d", c, valid, bus.num_retiring, bus.retired_count);
    end
  endtask

  task automatic test_reset_midrun();
    reset = 1'b0;
    t_new = '{6'd0, 6'd0, 6'd0};
    apply(2'd3, {64{1'b1}});
    n_cmp++;
    if (bus.num_retiring !== 2'd0) begin
      n_err++; $display("FAIL midreset_num got %0d want 0", bus.num_retiring);
    end
    tick();
    n_cmp++;
    if (bus.retired_count !== 32'd0) begin
      n_err++; $display("FAIL midreset_count got %0d want 0", bus.retired_count);
    end
    reset = 1'b1;
    exp_count = 0;
    $display("test_reset_midrun: count=%0d", bus.retired_count);
  endtask

  initial begin
    bus.rob_outputs           = '0;
    bus.rob_outputs_valid     = '0;
    bus.complete_list_exposed = '0;
    @(negedge clock);
    test_reset();
    test_partial_valid();
    test_blocked_prefix();
    test_zero_valid();
    test_no_dest();
    test_duplicates();
    test_random();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
